// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the SD block responder.
package sd_resp_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_SHIFT = 9;
  localparam int unsigned LBA_W        = 23;
  localparam int unsigned NUM_DRIVES   = 2;

  typedef enum logic [3:0] {
    IDLE,
    ACK_WAIT,
    RD_FETCH,
    RD_PUSH,
    WR_ADDR,
    WR_WAIT1,
    WR_WAIT2,
    WR_STORE,
    DONE
  } state_t;

  // Transfer latched at request time
  typedef struct packed {
    logic             drive;
    logic             is_write;
    logic             oor;
    logic [LBA_W-1:0] lba;
  } xfer_t;

endpackage

// File: rtl/sd_block_responder_if.sv
// SD block bus (controller side) plus byte-wide image memory port.
interface sd_block_responder_if #(
  parameter int unsigned MEM_AW = 25
);
  logic [1:0][31:0]  sd_lba;
  logic [1:0]        sd_rd;
  logic [1:0]        sd_wr;
  logic [1:0]        sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic [1:0][7:0]   sd_buff_din;
  logic              sd_buff_wr;
  logic [1:0]        img_mounted;
  logic [1:0][31:0]  img_size;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_mounted, img_size,
           mem_rdata, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, img_mounted, img_size,
           mem_rdata, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/sd_resp_mem_port.sv
// Image memory handshake: request held until mem_ready, completion flagged in that cycle.
module sd_resp_mem_port
  import sd_resp_pkg::*;
#(
  parameter int unsigned MEM_AW = 25
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              is_write,
  input  logic [MEM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              done_c,
  output logic [7:0]        rdata_c,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  logic busy_c;

  assign busy_c  = mem_rd | mem_wr;
  assign done_c  = busy_c & mem_ready;
  assign rdata_c = mem_rdata;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else if (!busy_c && start) begin
      mem_addr  <= addr;
      mem_wdata <= wdata;
      mem_rd    <= ~is_write;
      mem_wr    <= is_write;
    end else if (done_c) begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_block_responder.sv
// Answers sd_rd/sd_wr sector requests for two drives, streaming 512-byte sectors
// between the image memory and the controller sector buffer, one transfer at a time.
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int unsigned MEM_AW    = 25,
  parameter int unsigned IMG_BASE0 = 32'h0000_0000,
  parameter int unsigned IMG_BASE1 = 32'h0100_0000,
  parameter int unsigned ACK_DELAY = 4
) (
  input logic                   CLK,
  input logic                   RESET,
  sd_block_responder_if.slave   bus
);

  localparam logic [8:0] LAST_IDX = 9'(SECTOR_BYTES - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_DELAY - 1);

  state_t            state;
  xfer_t             xfer;
  logic [8:0]        idx;
  logic [7:0]        ack_cnt;
  logic              mem_start;
  logic [7:0]        wdata;

  logic [1:0]        req_c;
  logic              sel_d_c;
  logic              sel_wr_c;
  logic [LBA_W-1:0]  lba_c;
  logic              oor_c;
  logic [31:0]       img_base_c;
  logic [MEM_AW-1:0] byte_addr_c;
  logic              mem_done_c;
  logic [7:0]        mem_rdata_c;
  logic              unused_c;

  // Request scan: drive 0 first, read beats write on the same drive
  assign req_c    = bus.sd_rd | bus.sd_wr;
  assign sel_d_c  = ~req_c[0];
  assign sel_wr_c = ~bus.sd_rd[sel_d_c];
  assign lba_c    = bus.sd_lba[sel_d_c][LBA_W-1:0];
  assign oor_c    = ~bus.img_mounted[sel_d_c] |
                    (lba_c >= bus.img_size[sel_d_c][31:SECTOR_SHIFT]);

  assign img_base_c  = xfer.drive ? 32'(IMG_BASE1) : 32'(IMG_BASE0);
  assign byte_addr_c = MEM_AW'(img_base_c + {xfer.lba, idx});

  assign unused_c = ^{bus.sd_lba[0][31:LBA_W], bus.sd_lba[1][31:LBA_W],
                      bus.img_size[0][SECTOR_SHIFT-1:0], bus.img_size[1][SECTOR_SHIFT-1:0]};

  sd_resp_mem_port #(.MEM_AW(MEM_AW)) u_mem_port (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (mem_start),
    .is_write  (xfer.is_write),
    .addr      (byte_addr_c),
    .wdata     (wdata),
    .done_c    (mem_done_c),
    .rdata_c   (mem_rdata_c),
    .mem_addr  (bus.mem_addr),
    .mem_rd    (bus.mem_rd),
    .mem_wr    (bus.mem_wr),
    .mem_wdata (bus.mem_wdata),
    .mem_rdata (bus.mem_rdata),
    .mem_ready (bus.mem_ready)
  );

  // Transfer sequencer; out-of-range sectors skip memory but keep the full handshake
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      xfer         <= '0;
      idx          <= '0;
      ack_cnt      <= '0;
      mem_start    <= 1'b0;
      wdata        <= '0;
      bus.sd_ack       <= '0;
      bus.sd_buff_addr <= '0;
      bus.sd_buff_dout <= '0;
      bus.sd_buff_wr   <= 1'b0;
    end else begin
      mem_start      <= 1'b0;
      bus.sd_buff_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_c) begin
            xfer    <= '{drive: sel_d_c, is_write: sel_wr_c, oor: oor_c, lba: lba_c};
            idx     <= '0;
            ack_cnt <= '0;
            state   <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          if (ack_cnt == ACK_LAST) begin
            bus.sd_ack[xfer.drive] <= 1'b1;
            if (xfer.is_write) begin
              bus.sd_buff_addr <= idx;
              state            <= WR_ADDR;
            end else begin
              mem_start <= ~xfer.oor;
              state     <= RD_FETCH;
            end
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        RD_FETCH: begin
          if (xfer.oor || mem_done_c) begin
            bus.sd_buff_addr <= idx;
            bus.sd_buff_dout <= xfer.oor ? 8'h00 : mem_rdata_c;
            bus.sd_buff_wr   <= 1'b1;
            state            <= RD_PUSH;
          end
        end
        RD_PUSH: begin
          if (idx == LAST_IDX) begin
            bus.sd_ack       <= '0;
            bus.sd_buff_addr <= '0;
            state            <= DONE;
          end else begin
            idx       <= idx + 9'd1;
            mem_start <= ~xfer.oor;
            state     <= RD_FETCH;
          end
        end
        WR_ADDR:  state <= WR_WAIT1;
        WR_WAIT1: state <= WR_WAIT2;
        WR_WAIT2: begin
          wdata     <= bus.sd_buff_din[xfer.drive];
          mem_start <= ~xfer.oor;
          state     <= WR_STORE;
        end
        WR_STORE: begin
          if (xfer.oor || mem_done_c) begin
            if (idx == LAST_IDX) begin
              bus.sd_ack       <= '0;
              bus.sd_buff_addr <= '0;
              state            <= DONE;
            end else begin
              idx              <= idx + 9'd1;
              bus.sd_buff_addr <= idx + 9'd1;
              state            <= WR_ADDR;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
